// File: rtl/program_loader_uart.sv
// program_loader_uart: UART byte receiver with FIFO that feeds a CPU programming port.
module program_loader_uart #(
  parameter int CLKS_PER_BIT = 16,
  parameter int PROG_BYTES   = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  input  logic       cpu_ready,
  input  logic       cpu_done_load,
  output logic [7:0] prog_data,
  output logic       prog_valid,
  output logic       programming,
  output logic       frame_err,
  output logic       overflow,
  output logic       busy
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int XW = $clog2(PROG_BYTES + 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [XW-1:0] LAST = XW'(PROG_BYTES - 1);
  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} r_state_t;
  typedef enum logic [1:0] {L_IDLE, L_LOAD, L_WAIT, L_RUN} l_state_t;
  r_state_t r_state, r_nxt;
  l_state_t l_state, l_nxt;
  logic rx_m, rx_s;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [2:0] bidx, bidx_nxt;
  logic [7:0] sh, sh_nxt;
  logic brk, brk_nxt, push_r, push_nxt, ferr_nxt;
  logic [AW:0] wr_ptr, rd_ptr;
  logic [7:0] mem [FIFO_DEPTH];
  logic [XW-1:0] xfer_cnt;
  logic empty, full, pop, wr_en, flush;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      r_state <= R_IDLE;
      cnt <= '0;
      bidx <= '0;
      sh <= '0;
      brk <= 1'b0;
      push_r <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
      r_state <= r_nxt;
      cnt <= cnt_nxt;
      bidx <= bidx_nxt;
      sh <= sh_nxt;
      brk <= brk_nxt;
      push_r <= push_nxt;
      frame_err <= ferr_nxt;
    end
  // brk marks a failed stop bit: hold in R_STOP until the line returns high
  always_comb begin
    r_nxt = r_state;
    cnt_nxt = cnt + 1'b1;
    bidx_nxt = bidx;
    sh_nxt = sh;
    brk_nxt = brk;
    push_nxt = 1'b0;
    ferr_nxt = frame_err;
    case (r_state)
      R_IDLE: begin
        cnt_nxt = '0;
        r_nxt = rx_s ? R_IDLE : R_START;
      end
      R_START:
        if (cnt == HALF_M1) begin
          cnt_nxt = '0;
          bidx_nxt = '0;
          r_nxt = rx_s ? R_IDLE : R_DATA;
        end
      R_DATA:
        if (cnt == FULL_M1) begin
          cnt_nxt = '0;
          sh_nxt = {rx_s, sh[7:1]};
          bidx_nxt = bidx + 1'b1;
          r_nxt = (bidx == 3'd7) ? R_STOP : R_DATA;
        end
      R_STOP:
        if (brk) begin
          cnt_nxt = '0;
          brk_nxt = !rx_s;
          r_nxt = rx_s ? R_IDLE : R_STOP;
        end else if (cnt == FULL_M1) begin
          cnt_nxt = '0;
          push_nxt = rx_s;
          brk_nxt = !rx_s;
          ferr_nxt = frame_err | !rx_s;
          r_nxt = rx_s ? R_IDLE : R_STOP;
        end
    endcase
  end
  assign empty = (wr_ptr == rd_ptr);
  assign full = ((wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}});
  assign prog_valid = !empty && (l_state == L_LOAD);
  assign pop = prog_valid && cpu_ready;
  assign wr_en = push_r && (l_state != L_RUN) && (!full || pop);
  assign flush = (l_state == L_WAIT) && cpu_done_load;
  assign prog_data = empty ? 8'h00 : mem[rd_ptr[AW-1:0]];
  assign programming = (l_state == L_LOAD) || (l_state == L_WAIT);
  assign busy = (l_state != L_IDLE);
  always_ff @(posedge clk)
    if (wr_en) mem[wr_ptr[AW-1:0]] <= sh;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      overflow <= 1'b0;
      xfer_cnt <= '0;
      l_state <= L_IDLE;
    end else begin
      wr_ptr <= flush ? '0 : wr_ptr + {{AW{1'b0}}, wr_en};
      rd_ptr <= flush ? '0 : rd_ptr + {{AW{1'b0}}, pop};
      overflow <= overflow | (push_r && (l_state != L_RUN) && full && !pop);
      xfer_cnt <= xfer_cnt + {{(XW-1){1'b0}}, pop};
      l_state <= l_nxt;
    end
  always_comb begin
    l_nxt = l_state;
    case (l_state)
      L_IDLE: l_nxt = push_r ? L_LOAD : L_IDLE;
      L_LOAD: l_nxt = (pop && xfer_cnt == LAST) ? L_WAIT : L_LOAD;
      L_WAIT: l_nxt = cpu_done_load ? L_RUN : L_WAIT;
      default: l_nxt = L_RUN;
    endcase
  end
endmodule
